// File: rtl/stream_framer.sv
// Raster source: buffers handshaked pixels in a small FIFO and replays them over a
// free-running frame raster, stalling the raster when an active position finds no data.
module stream_framer #(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 3,
    parameter int IMAGE_WIDTH  = 4,
    parameter int FRAME_HEIGHT = 4,
    parameter int FRAME_WIDTH  = 6,
    parameter int FIFO_DEPTH   = 16,
    parameter int START_LEVEL  = FIFO_DEPTH / 2,
    localparam int V_BITW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1,
    localparam int H_BITW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_pixel,
    input  logic                 in_last,
    output logic                 out_enable,
    output logic [BIT_WIDTH-1:0] out_pixel,
    output logic [V_BITW-1:0]    out_vcnt,
    output logic [H_BITW-1:0]    out_hcnt,
    output logic                 err_sync
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  START_C = CNT_W'(START_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [V_BITW-1:0] V_ONE   = V_BITW'(1);
    localparam logic [H_BITW-1:0] H_ONE   = H_BITW'(1);
    localparam logic [V_BITW-1:0] V_LAST  = V_BITW'(FRAME_HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_LAST  = H_BITW'(FRAME_WIDTH - 1);
    localparam logic [V_BITW-1:0] IH_C    = V_BITW'(IMAGE_HEIGHT);
    localparam logic [H_BITW-1:0] IW_C    = H_BITW'(IMAGE_WIDTH);
    localparam logic [V_BITW-1:0] IH_END  = V_BITW'(IMAGE_HEIGHT - 1);
    localparam logic [H_BITW-1:0] IW_END  = H_BITW'(IMAGE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    logic [BIT_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     last_count;
    logic                 push;
    logic                 pop;
    logic [BIT_WIDTH-1:0] head_pixel;
    logic                 head_last;

    state_t               state;
    logic                 fresh;
    logic                 chk_bad;
    logic [V_BITW-1:0]    next_v;
    logic [H_BITW-1:0]    next_h;
    logic                 next_active;
    logic                 next_is_end;
    logic                 starve;
    logic                 advance;
    logic                 start_ok;

    assign in_ready   = count < DEPTH_C;
    assign push       = in_valid && in_ready;
    assign head_pixel = mem[rd_ptr][BIT_WIDTH-1:0];
    assign head_last  = mem[rd_ptr][BIT_WIDTH];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_pixel};
        end
    end

    // last_count tracks how many buffered entries close an image, for the early start.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            last_count <= last_count + CNT_W'(push && in_last) - CNT_W'(pop && head_last);
        end
    end

    // The first position after IDLE is (0,0); afterwards it is the successor of the output.
    always_comb begin
        next_v = '0;
        next_h = '0;
        if (!fresh) begin
            if (out_hcnt == H_LAST) begin
                next_h = '0;
                next_v = (out_vcnt == V_LAST) ? '0 : out_vcnt + V_ONE;
            end else begin
                next_h = out_hcnt + H_ONE;
                next_v = out_vcnt;
            end
        end
    end

    assign next_active = (next_v < IH_C) && (next_h < IW_C);
    assign next_is_end = (next_v == IH_END) && (next_h == IW_END);
    assign starve      = next_active && (count == '0);
    assign advance     = (state != IDLE) && !starve;
    assign pop         = advance && next_active;
    assign start_ok    = (count >= START_C) || (last_count != '0);

    // chk_bad flags a misaligned last bit together with the output; err_sync latches it next edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            fresh      <= 1'b1;
            out_enable <= 1'b0;
            out_pixel  <= '0;
            out_vcnt   <= '0;
            out_hcnt   <= '0;
            chk_bad    <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            chk_bad  <= 1'b0;
            err_sync <= err_sync | chk_bad;
            unique case (state)
                IDLE: begin
                    out_enable <= 1'b0;
                    fresh      <= 1'b1;
                    if (start_ok) begin
                        state <= RUN;
                    end
                end
                RUN, STALL: begin
                    if (starve) begin
                        state      <= STALL;
                        out_enable <= 1'b0;
                    end else begin
                        state      <= RUN;
                        fresh      <= 1'b0;
                        out_enable <= 1'b1;
                        out_vcnt   <= next_v;
                        out_hcnt   <= next_h;
                        out_pixel  <= next_active ? head_pixel : '0;
                        chk_bad    <= next_active && (head_last != next_is_end);
                    end
                end
                default: begin
                    state      <= IDLE;
                    out_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
